// File: rtl/gb_apu_pkg.sv
// Shared widths and waveform tables for the Game Boy style APU channels.
// Imported by the pulse channel and the reusable volume envelope.
package gb_apu_pkg;

  localparam int FREQ_W = 11;
  localparam int VOL_W  = 4;
  localparam int LEN_W  = 6;

  localparam logic [FREQ_W:0] FREQ_SPAN = 12'd2048;
  localparam logic [FREQ_W:0] FREQ_MAX  = 12'd2047;

  // Bit n of each entry is the output at duty step n.
  localparam logic [3:0][7:0] DUTY_TABLE = {
    8'b0111_1110,
    8'b1110_0001,
    8'b1000_0001,
    8'b1000_0000
  };

  function automatic logic duty_bit(
    input logic [1:0] duty,
    input logic [2:0] step
  );
    logic [7:0] row;
    row = DUTY_TABLE[duty];
    return row[step];
  endfunction

endpackage

// File: rtl/gb_vol_envelope.sv
// Volume envelope: holds the channel volume and its pace timer.
// Shared by the pulse and noise channels.
module gb_vol_envelope
  import gb_apu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trigger_i,
  input  logic             tick_i,
  input  logic [VOL_W-1:0] init_vol_i,
  input  logic             increasing_i,
  input  logic [2:0]       pace_i,
  output logic [VOL_W-1:0] volume_o
);

  localparam logic [VOL_W-1:0] VOL_TOP = '1;

  logic [VOL_W-1:0] vol_q, vol_d;
  logic [2:0]       timer_q, timer_d;

  always_comb begin
    vol_d   = vol_q;
    timer_d = timer_q;
    if (trigger_i) begin
      vol_d   = init_vol_i;
      timer_d = pace_i;
    end else if (tick_i && pace_i != 3'd0) begin
      // A stale zero timer counts as expiring so the envelope never stalls.
      if (timer_q <= 3'd1) begin
        timer_d = pace_i;
        if (increasing_i && vol_q != VOL_TOP) begin
          vol_d = vol_q + 1'b1;
        end else if (!increasing_i && vol_q != '0) begin
          vol_d = vol_q - 1'b1;
        end
      end else begin
        timer_d = timer_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vol_q   <= '0;
      timer_q <= '0;
    end else begin
      vol_q   <= vol_d;
      timer_q <= timer_d;
    end
  end

  assign volume_o = vol_q;

endmodule

// File: rtl/gb_pulse_channel.sv
// Square-wave channel with length counter, volume envelope and
// frequency sweep, clocked by frame-sequencer strobes.
module gb_pulse_channel
  import gb_apu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_length_ctr,
  input  logic              clk_vol_env,
  input  logic              clk_sweep,
  input  logic [2:0]        sweep_time,
  input  logic              sweep_decreasing,
  input  logic [2:0]        num_sweep_shifts,
  input  logic [1:0]        wave_duty,
  input  logic [LEN_W-1:0]  length,
  input  logic              single,
  input  logic [VOL_W-1:0]  initial_volume,
  input  logic              envelope_increasing,
  input  logic [2:0]        num_envelope_sweeps,
  input  logic              start,
  input  logic [FREQ_W-1:0] frequency,
  output logic [VOL_W-1:0]  level,
  output logic              enable
);

  logic              enable_q, enable_d;
  logic [LEN_W:0]    len_q, len_d;
  logic [FREQ_W-1:0] shadow_q, shadow_d;
  logic [3:0]        swp_tmr_q, swp_tmr_d;
  logic [FREQ_W:0]   frq_tmr_q, frq_tmr_d;
  logic [2:0]        step_q, step_d;
  logic [VOL_W-1:0]  level_q, level_d;
  logic [VOL_W-1:0]  volume;

  logic [FREQ_W:0]   shadow_x, delta, swp_new;
  logic [FREQ_W:0]   trig_x, trig_sum;
  logic [3:0]        swp_reload;
  logic              dac_off, trig_ovf;

  gb_vol_envelope u_env (
    .clk_i        (clk),
    .rst_i        (reset),
    .trigger_i    (start),
    .tick_i       (clk_vol_env & ~start),
    .init_vol_i   (initial_volume),
    .increasing_i (envelope_increasing),
    .pace_i       (num_envelope_sweeps),
    .volume_o     (volume)
  );

  always_comb begin
    shadow_x = {1'b0, shadow_q};
    delta    = shadow_x >> num_sweep_shifts;
    if (sweep_decreasing) begin
      swp_new = (delta > shadow_x) ? '0 : shadow_x - delta;
    end else begin
      swp_new = shadow_x + delta;
    end
    trig_x   = {1'b0, frequency};
    trig_sum = trig_x + (trig_x >> num_sweep_shifts);
    trig_ovf = (num_sweep_shifts != 3'd0) && !sweep_decreasing
               && (trig_sum > FREQ_MAX);
    dac_off  = (initial_volume == '0) && !envelope_increasing;
    swp_reload = (sweep_time == 3'd0) ? 4'd8 : {1'b0, sweep_time};
  end

  always_comb begin
    enable_d  = enable_q;
    len_d     = len_q;
    shadow_d  = shadow_q;
    swp_tmr_d = swp_tmr_q;
    if (start) begin
      enable_d  = !dac_off && !trig_ovf;
      len_d     = 7'd64 - {1'b0, length};
      shadow_d  = frequency;
      swp_tmr_d = swp_reload;
    end else begin
      if (clk_length_ctr && single && len_q != '0) begin
        len_d = len_q - 1'b1;
        if (len_q == 7'd1) begin
          enable_d = 1'b0;
        end
      end
      if (clk_sweep) begin
        if (swp_tmr_q <= 4'd1) begin
          swp_tmr_d = swp_reload;
          if (sweep_time != 3'd0) begin
            if (!sweep_decreasing && swp_new > FREQ_MAX) begin
              enable_d = 1'b0;
            end else if (num_sweep_shifts != 3'd0) begin
              shadow_d = swp_new[FREQ_W-1:0];
            end
          end
        end else begin
          swp_tmr_d = swp_tmr_q - 4'd1;
        end
      end
    end
  end

  // Reload from shadow_d so a sweep update lands on the very next period.
  always_comb begin
    frq_tmr_d = frq_tmr_q - 1'b1;
    step_d    = step_q;
    if (start) begin
      frq_tmr_d = FREQ_SPAN - {1'b0, frequency};
      step_d    = '0;
    end else if (frq_tmr_q <= 12'd1) begin
      frq_tmr_d = FREQ_SPAN - {1'b0, shadow_d};
      step_d    = step_q + 3'd1;
    end
  end

  always_comb begin
    level_d = '0;
    if (enable_q && duty_bit(wave_duty, step_q)) begin
      level_d = volume;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q  <= 1'b0;
      len_q     <= '0;
      shadow_q  <= '0;
      swp_tmr_q <= '0;
      frq_tmr_q <= '0;
      step_q    <= '0;
      level_q   <= '0;
    end else begin
      enable_q  <= enable_d;
      len_q     <= len_d;
      shadow_q  <= shadow_d;
      swp_tmr_q <= swp_tmr_d;
      frq_tmr_q <= frq_tmr_d;
      step_q    <= step_d;
      level_q   <= level_d;
    end
  end

  assign level  = level_q;
  assign enable = enable_q;

endmodule

// File: tb/tb_gb_pulse_channel.sv
// Scenario bench for gb_pulse_channel; expected values queue up as
// stimulus is applied and are popped as the channel responds.
module tb_gb_pulse_channel;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_length_ctr = 1'b0;
  logic        clk_vol_env = 1'b0;
  logic        clk_sweep = 1'b0;
  logic [2:0]  sweep_time = '0;
  logic        sweep_decreasing = 1'b0;
  logic [2:0]  num_sweep_shifts = '0;
  logic [1:0]  wave_duty = '0;
  logic [5:0]  length = '0;
  logic        single = 1'b0;
  logic [3:0]  initial_volume = '0;
  logic        envelope_increasing = 1'b0;
  logic [2:0]  num_envelope_sweeps = '0;
  logic        start = 1'b0;
  logic [10:0] frequency = '0;
  logic [3:0]  level;
  logic        enable;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e, got;

  gb_pulse_channel dut (
    .clk                 (clk),
    .reset               (reset),
    .clk_length_ctr      (clk_length_ctr),
    .clk_vol_env         (clk_vol_env),
    .clk_sweep           (clk_sweep),
    .sweep_time          (sweep_time),
    .sweep_decreasing    (sweep_decreasing),
    .num_sweep_shifts    (num_sweep_shifts),
    .wave_duty           (wave_duty),
    .length              (length),
    .single              (single),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .start               (start),
    .frequency           (frequency),
    .level               (level),
    .enable              (enable)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_default();
    sweep_time = 3'd7;
    sweep_decreasing = 1'b1;
    num_sweep_shifts = 3'd7;
    wave_duty = 2'b10;
    length = 6'd1;
    single = 1'b1;
    initial_volume = 4'd1;
    envelope_increasing = 1'b1;
    num_envelope_sweeps = 3'd7;
    frequency = 11'd2047;
  endtask

  task automatic trigger();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic measure_vol(output logic [3:0] v);
    v = '0;
    repeat (8) begin
      step();
      if (level > v) v = level;
    end
  endtask

  task automatic measure_period(output int p);
    int n;
    int t0;
    logic [3:0] prev;
    n = 0;
    t0 = -1;
    p = -1;
    prev = level;
    while (n < 1200 && p < 0) begin
      step();
      n++;
      if (prev == 4'd0 && level != 4'd0) begin
        if (t0 < 0) t0 = n;
        else p = n - t0;
      end
      prev = level;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    #2;
    e = exp_q.pop_front(); got = 16'(level); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset_level: got %0d expected %0d", got, e);
    end
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset_enable: got %0d expected %0d", got, e);
    end
    repeat (3) step();
    reset = 1'b0;
    cfg_default();
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    repeat (20) step();
    e = exp_q.pop_front(); got = 16'(level); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL silent_level: got %0d expected %0d", got, e);
    end
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL silent_enable: got %0d expected %0d", got, e);
    end
  endtask

  task automatic test_duty();
    logic [7:0] pat;
    cfg_default();
    pat = 8'b1110_0001;
    exp_q.push_back(16'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(pat[i]));
    trigger();
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL trig_enable: got %0d expected %0d", got, e);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      e = exp_q.pop_front(); got = 16'(level); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL duty_step%0d: got %0d expected %0d", i, got, e);
      end
    end
  endtask

  task automatic test_length();
    cfg_default();
    trigger();
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    for (int i = 0; i < 63; i++) begin
      clk_length_ctr = 1'b1;
      step();
      clk_length_ctr = 1'b0;
      if (i == 61) begin
        e = exp_q.pop_front(); got = 16'(enable); vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL len_62: got %0d expected %0d", got, e);
        end
      end
    end
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL len_63: got %0d expected %0d", got, e);
    end
    repeat (2) step();
    e = exp_q.pop_front(); got = 16'(level); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL len_level: got %0d expected %0d", got, e);
    end
    single = 1'b0;
    trigger();
    exp_q.push_back(16'd1);
    repeat (63) begin
      clk_length_ctr = 1'b1;
      step();
      clk_length_ctr = 1'b0;
    end
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL len_unused: got %0d expected %0d", got, e);
    end
  endtask

  task automatic test_envelope();
    logic [3:0] v;
    cfg_default();
    single = 1'b0;
    trigger();
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd15);
    exp_q.push_back(16'd15);
    repeat (7) begin
      clk_vol_env = 1'b1; step(); clk_vol_env = 1'b0;
    end
    measure_vol(v);
    e = exp_q.pop_front(); got = 16'(v); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL env_7: got %0d expected %0d", got, e);
    end
    repeat (91) begin
      clk_vol_env = 1'b1; step(); clk_vol_env = 1'b0;
    end
    measure_vol(v);
    e = exp_q.pop_front(); got = 16'(v); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL env_98: got %0d expected %0d", got, e);
    end
    repeat (14) begin
      clk_vol_env = 1'b1; step(); clk_vol_env = 1'b0;
    end
    measure_vol(v);
    e = exp_q.pop_front(); got = 16'(v); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL env_sat: got %0d expected %0d", got, e);
    end
  endtask

  task automatic test_sweep();
    int p;
    cfg_default();
    single = 1'b0;
    trigger();
    // 8 duty steps per waveform cycle, each 2048-shadow clocks long
    exp_q.push_back(16'(8 * (2048 - 2032)));
    exp_q.push_back(16'(8 * (2048 - 2017)));
    repeat (7) begin
      clk_sweep = 1'b1; step(); clk_sweep = 1'b0;
    end
    measure_period(p);
    e = exp_q.pop_front(); got = 16'(p); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL sweep_2032: got %0d expected %0d", got, e);
    end
    repeat (7) begin
      clk_sweep = 1'b1; step(); clk_sweep = 1'b0;
    end
    measure_period(p);
    e = exp_q.pop_front(); got = 16'(p); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL sweep_2017: got %0d expected %0d", got, e);
    end
  endtask

  task automatic test_overflow();
    cfg_default();
    frequency = 11'd1500;
    sweep_decreasing = 1'b0;
    num_sweep_shifts = 3'd1;
    trigger();
    exp_q.push_back(16'd0);
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL trig_ovf: got %0d expected %0d", got, e);
    end
    num_sweep_shifts = 3'd0;
    trigger();
    exp_q.push_back(16'd1);
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL trig_noshift: got %0d expected %0d", got, e);
    end
    cfg_default();
    initial_volume = 4'd0;
    envelope_increasing = 1'b0;
    trigger();
    exp_q.push_back(16'd0);
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL dac_off: got %0d expected %0d", got, e);
    end
    envelope_increasing = 1'b1;
    trigger();
    exp_q.push_back(16'd1);
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL dac_on: got %0d expected %0d", got, e);
    end
  endtask

  task automatic test_async_reset();
    cfg_default();
    single = 1'b0;
    wave_duty = 2'b11;
    initial_volume = 4'd15;
    num_envelope_sweeps = 3'd0;
    trigger();
    repeat (3) step();
    exp_q.push_back(16'd15);
    e = exp_q.pop_front(); got = 16'(level); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL tone_level: got %0d expected %0d", got, e);
    end
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd0);
    #2 reset = 1'b1;
    #1;
    e = exp_q.pop_front(); got = 16'(level); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL async_level: got %0d expected %0d", got, e);
    end
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL async_enable: got %0d expected %0d", got, e);
    end
    reset = 1'b0;
    repeat (6) step();
    e = exp_q.pop_front(); got = 16'(level); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL post_rst_level: got %0d expected %0d", got, e);
    end
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL post_rst_enable: got %0d expected %0d", got, e);
    end
  endtask

  task automatic test_priority();
    cfg_default();
    length = 6'd10;
    clk_length_ctr = 1'b1;
    trigger();
    clk_length_ctr = 1'b0;
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd0);
    repeat (53) begin
      clk_length_ctr = 1'b1; step(); clk_length_ctr = 1'b0;
    end
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL prio_53: got %0d expected %0d", got, e);
    end
    clk_length_ctr = 1'b1; step(); clk_length_ctr = 1'b0;
    e = exp_q.pop_front(); got = 16'(enable); vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL prio_54: got %0d expected %0d", got, e);
    end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_length();
    test_envelope();
    test_sweep();
    test_overflow();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
